// File: rtl/i2s_decoder.sv
// ---------------------------------------------------------------------------
// i2s_decoder
//   I2S receiver for a stereo stream. The MSB arrives one BCLK after each
//   LRCLK edge, and each channel slot is SLOT_BITS BCLKs long. The receiver
//   deserialises each slot into a parallel word and publishes a left/right
//   pair only after the whole frame has been received with correct slot
//   lengths. All logic runs on the rising edge of i_bclk, because the
//   transmitter launches data on the falling edge.
//
// Ports
//   i_bclk    bit clock
//   i_rst     asynchronous reset, active-high
//   i_lrclk   word select (0 = left slot, 1 = right slot)
//   i_sdata   serial data, MSB first
//   o_data_l  last complete left word
//   o_data_r  last complete right word, from the same frame as o_data_l
//   o_valid   one-cycle pulse when o_data_l/o_data_r update
//   o_locked  high while frames arrive with the correct slot length
//   o_error   one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module i2s_decoder #(
  parameter int DATA_BITS = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                 i_bclk,
  input  logic                 i_rst,
  input  logic                 i_lrclk,
  input  logic                 i_sdata,
  output logic [DATA_BITS-1:0] o_data_l,
  output logic [DATA_BITS-1:0] o_data_r,
  output logic                 o_valid,
  output logic                 o_locked,
  output logic                 o_error
);

  localparam int CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  state_t               state_q, state_d;
  logic                 lr_q;             // LRCLK delayed by one BCLK
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;   // left word waiting for its right partner
  logic [DATA_BITS-1:0] data_l_q, data_l_d;
  logic [DATA_BITS-1:0] data_r_q, data_r_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 locked_q, locked_d;
  logic                 fall, rise, lr_edge, slot_full;

  always_comb begin
    fall      = lr_q & ~i_lrclk;
    rise      = ~lr_q & i_lrclk;
    lr_edge   = fall | rise;
    slot_full = (cnt_q == CNT_MAX);
    // Saturating slot position; never wraps, so a stuck LRCLK stays visible.
    cnt_inc   = slot_full ? cnt_q : cnt_q + CNT_W'(1);

    state_d  = state_q;
    cnt_d    = lr_edge ? '0 : cnt_inc;
    shift_d  = shift_q;
    hold_d   = hold_q;
    data_l_d = data_l_q;
    data_r_d = data_r_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    locked_d = locked_q;

    case (state_q)
      HUNT: begin
        // Only a falling edge marks a trustworthy frame start; all else waits.
        if (fall) begin
          state_d = LEFT;
          shift_d = '0;
        end
      end
      LEFT, RIGHT: begin
        if (lr_edge) begin
          if (slot_full && (state_q == LEFT) && rise) begin
            hold_d  = shift_q;
            shift_d = '0;
            state_d = RIGHT;
          end else if (slot_full && (state_q == RIGHT) && fall) begin
            data_l_d = hold_q;
            data_r_d = shift_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            shift_d  = '0;
            state_d  = LEFT;
          end else begin
            // Short slot: a fall is still a valid frame start, so resync
            // straight into LEFT; a rise leaves us mid-frame, so hunt.
            error_d  = 1'b1;
            locked_d = 1'b0;
            shift_d  = '0;
            state_d  = fall ? LEFT : HUNT;
          end
        end else if (slot_full) begin
          // Overlong slot or stuck LRCLK.
          error_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = HUNT;
        end else if (cnt_inc <= DATA_LAST) begin
          // cnt_inc is at least 1 here; position 1 is the MSB, beyond
          // DATA_BITS is padding.
          shift_d    = shift_q << 1;
          shift_d[0] = i_sdata;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge i_bclk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= HUNT;
      lr_q     <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      data_l_q <= '0;
      data_r_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lr_q     <= i_lrclk;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      data_l_q <= data_l_d;
      data_r_q <= data_r_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      locked_q <= locked_d;
    end
  end

  assign o_data_l = data_l_q;
  assign o_data_r = data_r_q;
  assign o_valid  = valid_q;
  assign o_error  = error_q;
  assign o_locked = locked_q;

endmodule

// File: tb/tb_i2s_decoder.sv
// ---------------------------------------------------------------------------
// tb_i2s_decoder
//   Scoreboard bench for i2s_decoder (DATA_BITS=16, SLOT_BITS=32). The
//   stimulus process drives an I2S stream on the falling BCLK edge and
//   pushes the expected {left,right} pair for every frame that should
//   decode. A monitor samples on the falling edge, pops and compares on each
//   o_valid, and logs valid/error times for the timing checks.
// ---------------------------------------------------------------------------
module tb_i2s_decoder;

  logic        i_bclk = 1'b0;
  logic        i_rst  = 1'b1;
  logic        i_lrclk = 1'b0;
  logic        i_sdata = 1'b0;
  logic [15:0] o_data_l, o_data_r;
  logic        o_valid, o_locked, o_error;

  i2s_decoder #(.DATA_BITS(16), .SLOT_BITS(32)) dut (
    .i_bclk   (i_bclk),
    .i_rst    (i_rst),
    .i_lrclk  (i_lrclk),
    .i_sdata  (i_sdata),
    .o_data_l (o_data_l),
    .o_data_r (o_data_r),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_error  (o_error)
  );

  always #5 i_bclk = ~i_bclk;

  int cyc = 0;
  always @(posedge i_bclk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerrors = 0;
  int nvalid  = 0;
  int nerr    = 0;
  int slot_cyc  = 0;
  int frame_cyc = 0;
  logic [31:0] exp_q[$];
  int vtimes[$];
  int etimes[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge i_bclk) begin
    if (o_valid || o_error)
      check("valid_error_exclusive", 32'(o_valid & o_error), 32'd0);
    if (o_valid) begin
      nvalid++;
      vtimes.push_back(cyc);
      check("locked_with_valid", 32'(o_locked), 32'd1);
      if (exp_q.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL unexpected_valid: got L=0x%04h R=0x%04h, required no valid", o_data_l, o_data_r);
      end else begin
        check("valid_data", {o_data_l, o_data_r}, exp_q.pop_front());
      end
    end
    if (o_error) begin
      nerr++;
      etimes.push_back(cyc);
    end
  end

  // One slot of 'len' BCLKs: position 0 is the I2S delay bit, 1..16 carry
  // the word MSB first, the rest is padding.
  task automatic send_slot(input logic ch, input logic [15:0] w, input int len, input logic pad);
    for (int k = 0; k < len; k++) begin
      @(negedge i_bclk);
      i_lrclk = ch;
      i_sdata = (k >= 1 && k <= 16) ? w[16-k] : pad;
      if (k == 0) slot_cyc = cyc;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pad);
    exp_q.push_back({l, r});
    send_slot(1'b0, l, 32, pad);
    frame_cyc = slot_cyc;
    send_slot(1'b1, r, 32, pad);
  endtask

  task automatic do_reset(input logic lr);
    @(negedge i_bclk);
    i_rst   = 1'b1;
    i_lrclk = lr;
    i_sdata = 1'b0;
    repeat (2) @(negedge i_bclk);
    exp_q.delete();
    vtimes.delete();
    etimes.delete();
    i_rst = 1'b0;
  endtask

  int n0, e0, t;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_data_l", 32'(o_data_l), 32'd0);
    check("rst_data_r", 32'(o_data_r), 32'd0);
    check("rst_valid",  32'(o_valid),  32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_error",  32'(o_error),  32'd0);

    // 1: steady encoder-format stream
    do_reset(1'b0);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    send_frame(16'hA5C3, 16'h1234, 1'b0);
    check("t1_locked_before", 32'(o_locked), 32'd0);
    check("t1_no_early_valid", 32'(nvalid - n0), 32'd0);
    send_frame(16'hA5C3, 16'h1234, 1'b0);
    t = frame_cyc;
    send_frame(16'hA5C3, 16'h1234, 1'b0);
    send_slot(1'b0, 16'h0000, 4, 1'b0);
    check("t1_valid_count", 32'(nvalid - n0), 32'd3);
    check("t1_error_count", 32'(nerr - e0), 32'd0);
    check("t1_locked", 32'(o_locked), 32'd1);
    check("t1_hold", {o_data_l, o_data_r}, 32'hA5C3_1234);
    if (vtimes.size() == 3) begin
      check("t1_first_valid_cycle", 32'(vtimes[0]), 32'(t + 1));
      check("t1_spacing_a", 32'(vtimes[1] - vtimes[0]), 32'd64);
      check("t1_spacing_b", 32'(vtimes[2] - vtimes[1]), 32'd64);
    end
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: reset released mid-right-slot, padding driven high
    do_reset(1'b1);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h3C3C, 10, 1'b1);
    send_frame(16'h8001, 16'h7FFE, 1'b1);
    check("t2_no_early_valid", 32'(nvalid - n0), 32'd0);
    send_frame(16'h8001, 16'h7FFE, 1'b1);
    send_slot(1'b0, 16'h0000, 4, 1'b1);
    check("t2_valid_count", 32'(nvalid - n0), 32'd2);
    check("t2_error_count", 32'(nerr - e0), 32'd0);
    check("t2_hold", {o_data_l, o_data_r}, 32'h8001_7FFE);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: short right slot, then resync
    do_reset(1'b0);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    send_frame(16'h1111, 16'h2222, 1'b0);
    send_slot(1'b0, 16'h3333, 32, 1'b0);
    send_slot(1'b1, 16'h4444, 20, 1'b0);
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    send_slot(1'b0, 16'h0F0F, 32, 1'b0);
    t = slot_cyc;
    check("t3_error_count", 32'(nerr - e0), 32'd1);
    if (etimes.size() == 1)
      check("t3_error_cycle", 32'(etimes[0]), 32'(t + 1));
    check("t3_unlocked", 32'(o_locked), 32'd0);
    check("t3_retained", {o_data_l, o_data_r}, 32'h1111_2222);
    send_slot(1'b1, 16'hF0F0, 32, 1'b0);
    send_slot(1'b0, 16'h0000, 4, 1'b0);
    check("t3_valid_count", 32'(nvalid - n0), 32'd2);
    check("t3_relocked", 32'(o_locked), 32'd1);
    check("t3_hold", {o_data_l, o_data_r}, 32'h0F0F_F0F0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: LRCLK stuck low for 40 BCLKs
    do_reset(1'b0);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    send_frame(16'h1357, 16'h2468, 1'b0);
    send_slot(1'b0, 16'h0000, 40, 1'b0);
    t = slot_cyc;
    check("t4_error_count", 32'(nerr - e0), 32'd1);
    if (etimes.size() == 1)
      check("t4_error_cycle", 32'(etimes[0]), 32'(t + 33));
    check("t4_unlocked", 32'(o_locked), 32'd0);
    check("t4_retained", {o_data_l, o_data_r}, 32'h1357_2468);
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    send_frame(16'hCAFE, 16'hBEEF, 1'b0);
    send_slot(1'b0, 16'h0000, 4, 1'b0);
    check("t4_valid_count", 32'(nvalid - n0), 32'd2);
    check("t4_error_total", 32'(nerr - e0), 32'd1);
    check("t4_relocked", 32'(o_locked), 32'd1);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: one-cycle reset mid-left-slot of a locked stream
    do_reset(1'b0);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    send_frame(16'h1111, 16'h2222, 1'b0);
    send_slot(1'b0, 16'h3333, 10, 1'b0);
    check("t5_locked_before", 32'(o_locked), 32'd1);
    @(negedge i_bclk);
    i_rst = 1'b1;
    #1;
    check("t5_rst_data", {o_data_l, o_data_r}, 32'd0);
    check("t5_rst_flags", {29'd0, o_valid, o_locked, o_error}, 32'd0);
    @(negedge i_bclk);
    i_rst = 1'b0;
    send_slot(1'b0, 16'h0000, 20, 1'b0);
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    send_frame(16'h5555, 16'hAAAA, 1'b0);
    send_slot(1'b0, 16'h0000, 4, 1'b0);
    check("t5_valid_count", 32'(nvalid - n0), 32'd2);
    check("t5_error_count", 32'(nerr - e0), 32'd0);
    check("t5_hold", {o_data_l, o_data_r}, 32'h5555_AAAA);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: back-to-back alternating extremes
    do_reset(1'b0);
    n0 = nvalid; e0 = nerr;
    send_slot(1'b1, 16'h0000, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send_frame(16'hFFFF, 16'h0000, 1'b0);
      else            send_frame(16'h0000, 16'hFFFF, 1'b0);
    end
    send_slot(1'b0, 16'h0000, 4, 1'b0);
    check("t6_valid_count", 32'(nvalid - n0), 32'd8);
    check("t6_error_count", 32'(nerr - e0), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/i2s_decoder.md
Name: i2s_decoder

Overview:
- I2S receiver: deserialises a 16-bit stereo I2S stream (MSB one BCLK after the LRCLK edge, 32-BCLK slots) into parallel left/right words.
- Counterpart of the team's I2S encoder; used for loopback verification and for ingesting external codec/ADC audio at BCLK 6.144 MHz / LR 96 kHz.
- Runs entirely in the i_bclk domain and samples on the rising edge, since the transmitter launches on the falling edge.

Parameters:
- DATA_BITS, 16: audio bits per channel, MSB first. Legal range 1..SLOT_BITS-1.
- SLOT_BITS, 32: BCLK periods per LRCLK half-period, i.e. per channel slot.

Ports:
- i_bclk  in  1  bit clock. All logic on the rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_lrclk  in  1  word select. 0 = left slot, 1 = right slot.
- i_sdata  in  1  serial data.
- o_data_l  out  DATA_BITS  last complete left word.
- o_data_r  out  DATA_BITS  last complete right word, same frame as o_data_l.
- o_valid  out  1  one-cycle pulse when o_data_l/o_data_r update.
- o_locked  out  1  high while frames are arriving with correct slot length.
- o_error  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset values (i_rst high):
  - state = HUNT
  - r_lr_d = 0
  - counter = 0
  - shift/hold registers = 0
  - o_data_l = o_data_r = 0
  - o_valid = o_error = o_locked = 0
  - Reset mid-frame discards the partial frame; outputs clear immediately.
- Edge detect: r_lr_d registers i_lrclk every cycle.
  - fall = r_lr_d & !i_lrclk
  - rise = !r_lr_d & i_lrclk
  - edge = fall | rise
- Slot counter (width clog2(SLOT_BITS)):
  - edge: counter <= 0. The edge cycle is the I2S delay bit and its data is ignored.
  - otherwise: counter increments, saturating at SLOT_BITS-1.
- Capture: in LEFT or RIGHT, on a non-edge cycle where the new counter value p is in 1..DATA_BITS, shift i_sdata into the shift register LSB, shifting left. Bit p = 1 is the MSB. Bits at p > DATA_BITS are ignored (padding).
- Length check: an edge in LEFT or RIGHT is "good" only if counter == SLOT_BITS-1 before the edge.
- State machine:
  - HUNT:
    - fall -> LEFT; clear shift register.
    - Everything else is ignored, including rise and a start mid-right-slot.
    - No error pulses are generated in HUNT.
  - LEFT, good rise:
    - hold <= shift register; clear shift register -> RIGHT.
  - RIGHT, good fall:
    - o_data_l <= hold; o_data_r <= shift register (same cycle).
    - o_valid = 1 for that cycle; o_locked <= 1.
    - Clear shift register -> LEFT.
  - LEFT or RIGHT, edge with wrong length (short slot):
    - o_error = 1; o_locked <= 0; outputs unchanged, no o_valid.
    - If the edge is a fall -> LEFT (immediate resync, shift register cleared); if a rise -> HUNT.
  - LEFT or RIGHT, no edge while counter is already SLOT_BITS-1 (overlong slot / stuck LRCLK):
    - o_error = 1; o_locked <= 0 -> HUNT.
- Latency: o_valid asserts on the rising edge where LRCLK is first sampled low after the right slot, i.e. SLOT_BITS-DATA_BITS BCLKs after the right LSB is sampled.
- First valid after reset needs one full left+right frame following the first falling LRCLK edge.
- o_data_l/o_data_r hold between o_valid pulses. Only whole, length-checked frames update them.
- o_valid and o_error are never high in the same cycle.

Test Plan:
- Encoder-format stream, L=0xA5C3, R=0x1234, three frames -> o_valid pulses once per 64 BCLKs; o_data_l=0xA5C3, o_data_r=0x1234. First pulse on the LRCLK-low sample ending frame 1; o_locked rises with it; o_error never pulses.
- Release reset with LRCLK high, mid-right-slot, then frames L=0x8001, R=0x7FFE -> no o_valid until a full left+right frame after the first fall; then 0x8001/0x7FFE. Padding bits driven to 1 must not alter the words.
- Locked stream, then a right slot cut to 20 BCLKs before the fall, next frame L=0x0F0F, R=0xF0F0 -> o_error one cycle at the short fall; o_locked=0; previous words retained; resync in LEFT. Next o_valid gives 0x0F0F/0xF0F0 with o_locked=1.
- Locked stream, then LRCLK held low for 40 BCLKs -> o_error pulses on the 32nd post-edge cycle (counter saturated, no edge); state HUNT; o_locked=0. Normal frames resume with o_valid after one full frame.
- Assert i_rst for 1 BCLK mid-left-slot of a locked stream -> all outputs 0 immediately. Decode of L=0x5555, R=0xAAAA resumes after the next fall plus one full frame.
- Back-to-back frames alternating 0xFFFF/0x0000 and 0x0000/0xFFFF for 8 frames -> each o_valid carries the matching pair with no channel swap and no bit slip.
